// File: rtl/return_addr_stack.sv
// Circular return-address LIFO beside the PC mux; pushes on CALL, pops on RET.
// Latency: pushed value visible on DOUT the cycle after the edge. Never stalls: overflow wraps, underflow is ignored.
module return_addr_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [ADDR_W-1:0] DIN,
    input  logic              CLR_ERR,
    output logic [ADDR_W-1:0] DOUT,
    output logic [PTR_W:0]    COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVF,
    output logic              UNF
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_tp;
    logic [PTR_W:0]    r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [PTR_W-1:0]  w_waddr;
    logic [PTR_W-1:0]  w_tp_nxt;
    logic [PTR_W:0]    w_count_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_tp;
        w_tp_nxt    = r_tp;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (PUSH && POP && !w_empty) begin
            // simultaneous CALL/RET: overwrite top in place, no flags
            w_we = 1'b1;
        end else if (PUSH) begin
            w_we     = 1'b1;
            w_tp_nxt = r_tp + PTR_W'(1);
            w_waddr  = r_tp + PTR_W'(1);
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_count_nxt = r_count + (PTR_W+1)'(1);
            end
        end else if (POP) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_tp_nxt    = r_tp - PTR_W'(1);
                w_count_nxt = r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_tp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_we) begin
                r_mem[w_waddr] <= DIN;
            end
            r_tp    <= w_tp_nxt;
            r_count <= w_count_nxt;
            // a new error event takes priority over CLR_ERR
            r_ovf   <= w_ovf_set | (r_ovf & ~CLR_ERR);
            r_unf   <= w_unf_set | (r_unf & ~CLR_ERR);
        end
    end

    assign DOUT  = w_empty ? '0 : r_mem[r_tp];
    assign COUNT = r_count;
    assign EMPTY = w_empty;
    assign FULL  = w_full;
    assign OVF   = r_ovf;
    assign UNF   = r_unf;

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed test-plan steps then random traffic against a queue model.
module tb_return_addr_stack;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              PUSH = 1'b0;
    logic              POP = 1'b0;
    logic [ADDR_W-1:0] DIN = '0;
    logic              CLR_ERR = 1'b0;
    logic [ADDR_W-1:0] DOUT;
    logic [PTR_W:0]    COUNT;
    logic              EMPTY, FULL, OVF, UNF;

    int tests = 0;
    int fails = 0;

    // Reference model: oldest entry at front, top of stack at back
    logic [ADDR_W-1:0] q[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .DIN(DIN), .CLR_ERR(CLR_ERR),
        .DOUT(DOUT), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input bit p, input bit o, input logic [ADDR_W-1:0] d, input bit c);
        bit ov = 0;
        bit un = 0;
        if (p && o && q.size() > 0) begin
            q[q.size()-1] = d;
        end else if (p) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                ov = 1;
            end
            q.push_back(d);
        end else if (o) begin
            if (q.size() == 0) un = 1;
            else void'(q.pop_back());
        end
        m_ovf = ov | (m_ovf & !c);
        m_unf = un | (m_unf & !c);
    endfunction

    task automatic check_all(input string tag);
        logic [ADDR_W-1:0] exp_dout;
        exp_dout = (q.size() > 0) ? q[q.size()-1] : '0;
        chk({tag, ".dout"},  32'(DOUT),  32'(exp_dout));
        chk({tag, ".count"}, 32'(COUNT), 32'(q.size()));
        chk({tag, ".empty"}, 32'(EMPTY), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(FULL),  32'(q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(OVF),   32'(m_ovf));
        chk({tag, ".unf"},   32'(UNF),   32'(m_unf));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check just after it
    task automatic step(input string tag, input bit p, input bit o, input logic [ADDR_W-1:0] d, input bit c);
        PUSH = p; POP = o; DIN = d; CLR_ERR = c;
        @(posedge CLK);
        model_step(p, o, d, c);
        #1;
        PUSH = 0; POP = 0; CLR_ERR = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        RST = 1'b0;
        @(posedge CLK); #1;

        // 1: reset then idle
        check_all("reset");
        for (int i = 0; i < 3; i++) step("idle", 0, 0, '0, 0);

        // 2: simple LIFO order
        step("p10", 1, 0, 10'h010, 0);
        step("p20", 1, 0, 10'h020, 0);
        step("p30", 1, 0, 10'h030, 0);
        chk("t2.top30", 32'(DOUT), 32'h030);
        step("pop1", 0, 1, '0, 0);
        chk("t2.top20", 32'(DOUT), 32'h020);
        step("pop2", 0, 1, '0, 0);
        chk("t2.top10", 32'(DOUT), 32'h010);
        step("pop3", 0, 1, '0, 0);
        chk("t2.empty", 32'(EMPTY), 32'h1);

        // 3: overflow wraps and loses the oldest entry
        for (int i = 1; i <= 9; i++) begin
            step("ovfpush", 1, 0, ADDR_W'(32'h100 + i), 0);
            if (i == 8) chk("t3.full8", 32'(FULL), 32'h1);
        end
        chk("t3.ovf", 32'(OVF), 32'h1);
        chk("t3.cnt", 32'(COUNT), 32'd8);
        chk("t3.top", 32'(DOUT), 32'h109);
        for (int k = 0; k < 8; k++) begin
            chk("t3.popval", 32'(DOUT), 32'h109 - 32'(k));
            step("ovfpop", 0, 1, '0, 0);
        end
        chk("t3.drained", 32'(COUNT), 32'd0);
        step("clr", 0, 0, '0, 1);

        // 4: underflow and clear
        step("unf", 0, 1, '0, 0);
        chk("t4.unf", 32'(UNF), 32'h1);
        step("clrunf", 0, 0, '0, 1);
        chk("t4.unfclr", 32'(UNF), 32'h0);

        // 5: simultaneous push+pop, non-empty then empty
        step("p11", 1, 0, 10'h011, 0);
        step("p55", 1, 0, 10'h055, 0);
        step("pp3ff", 1, 1, 10'h3FF, 0);
        chk("t5.dout", 32'(DOUT), 32'h3FF);
        chk("t5.cnt", 32'(COUNT), 32'd2);
        step("drain1", 0, 1, '0, 0);
        step("drain2", 0, 1, '0, 0);
        step("pp044", 1, 1, 10'h044, 0);
        chk("t5.edout", 32'(DOUT), 32'h044);
        chk("t5.eunf", 32'(UNF), 32'h0);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 3; i++) step("prerst", 1, 0, ADDR_W'(32'h200 + i), 0);
        @(negedge CLK); #1;
        RST = 1'b1;
        model_reset();
        #1;
        chk("t6.async.cnt", 32'(COUNT), 32'd0);
        chk("t6.async.dout", 32'(DOUT), 32'h0);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check_all("t6.afterrst");
        step("p77", 1, 0, 10'h077, 0);
        chk("t6.dout77", 32'(DOUT), 32'h077);

        // Random traffic biased toward pushes then pops to reach both ends
        for (int n = 0; n < 600; n++) begin
            bit p, o, c;
            int bias;
            bias = ((n / 60) % 2 == 0) ? 65 : 35;
            p = ($urandom_range(99) < bias);
            o = ($urandom_range(99) < 100 - bias);
            c = ($urandom_range(15) == 0);
            step("rand", p, o, ADDR_W'($urandom), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
